// File: rtl/multi_retire_block_fsm_pkg.sv
// Shared types and widths for the multi-lane retire block grouper.
// Lane records, FSM state encoding and instruction-type codes.
package mure_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned CAUSE_LEN   = 5;
  localparam int unsigned PRIV_LEN    = 2;
  localparam int unsigned ITYPE_LEN   = 4;
  localparam int unsigned IRETIRE_LEN = 8;

  localparam logic [ITYPE_LEN-1:0] ITYPE_STD = 4'd0;
  localparam logic [ITYPE_LEN-1:0] ITYPE_EXC = 4'd1;
  localparam logic [ITYPE_LEN-1:0] ITYPE_INT = 4'd2;

  typedef enum logic {
    IDLE,
    COUNT
  } state_e;

  typedef struct packed {
    logic                 valid;
    logic [XLEN-1:0]      pc;
    logic [ITYPE_LEN-1:0] itype;
    logic                 compressed;
    logic [PRIV_LEN-1:0]  priv;
  } uop_entry_s;

  function automatic logic is_event(input logic [ITYPE_LEN-1:0] t);
    return (t == ITYPE_EXC) || (t == ITYPE_INT);
  endfunction

endpackage

// File: rtl/multi_retire_block_fsm_lane_step.sv
// One lane of the retire scan: folds a uop into the running block
// carry and reports any block it closes.
module retire_lane_step
  import mure_pkg::*;
#(
  parameter int unsigned IRETIRE_LEN = mure_pkg::IRETIRE_LEN,
  parameter bit          SAT_EN      = 1'b1
) (
  input  logic                   open_i,
  input  logic [XLEN-1:0]        iaddr_i,
  input  logic [IRETIRE_LEN-1:0] count_i,
  input  logic                   last_i,
  input  uop_entry_s             uop_i,
  input  logic [CAUSE_LEN-1:0]   cause_i,
  input  logic [XLEN-1:0]        tval_i,
  output logic                   open_o,
  output logic [XLEN-1:0]        iaddr_o,
  output logic [IRETIRE_LEN-1:0] count_o,
  output logic                   last_o,
  output logic                   sat_o,
  output logic                   close_o,
  output logic [XLEN-1:0]        blk_iaddr_o,
  output logic [IRETIRE_LEN-1:0] blk_cnt_o,
  output logic                   blk_last_o,
  output logic [ITYPE_LEN-1:0]   blk_itype_o,
  output logic [CAUSE_LEN-1:0]   blk_cause_o,
  output logic [XLEN-1:0]        blk_tval_o,
  output logic [PRIV_LEN-1:0]    blk_priv_o
);

  logic [IRETIRE_LEN-1:0] inc;
  logic [IRETIRE_LEN:0]   sum;
  logic                   open_w;
  logic [IRETIRE_LEN-1:0] cnt_w;
  logic [IRETIRE_LEN-1:0] acc_w;
  logic [XLEN-1:0]        start_w;

  assign inc = !uop_i.valid ? '0 :
               (uop_i.compressed ? IRETIRE_LEN'(1) : IRETIRE_LEN'(2));
  assign sum = {1'b0, count_i} + {1'b0, inc};
  // carry out of the count means the open block would overflow
  assign sat_o   = SAT_EN && open_i && sum[IRETIRE_LEN];
  assign open_w  = open_i & ~sat_o;
  assign cnt_w   = sat_o ? '0 : count_i;
  assign acc_w   = cnt_w + inc;
  assign start_w = open_w ? iaddr_i : uop_i.pc;

  always_comb begin
    open_o      = open_w;
    iaddr_o     = iaddr_i;
    count_o     = cnt_w;
    last_o      = last_i;
    close_o     = 1'b0;
    blk_iaddr_o = '0;
    blk_cnt_o   = '0;
    blk_last_o  = 1'b0;
    blk_itype_o = '0;
    blk_cause_o = '0;
    blk_tval_o  = '0;
    blk_priv_o  = '0;
    if (is_event(uop_i.itype)) begin
      close_o     = 1'b1;
      blk_itype_o = uop_i.itype;
      blk_cause_o = cause_i;
      blk_tval_o  = (uop_i.itype == ITYPE_EXC) ? tval_i : '0;
      blk_priv_o  = uop_i.priv;
      if (uop_i.valid) begin
        blk_iaddr_o = start_w;
        blk_cnt_o   = acc_w;
        blk_last_o  = !uop_i.compressed;
      end else begin
        blk_iaddr_o = iaddr_i;
        blk_cnt_o   = cnt_w;
        blk_last_o  = last_i;
      end
      open_o  = 1'b0;
      count_o = '0;
      iaddr_o = blk_iaddr_o;
      last_o  = blk_last_o;
    end else if (uop_i.valid) begin
      if (uop_i.itype == ITYPE_STD) begin
        open_o  = 1'b1;
        iaddr_o = start_w;
        count_o = acc_w;
        last_o  = !uop_i.compressed;
      end else begin
        close_o     = 1'b1;
        blk_itype_o = uop_i.itype;
        blk_priv_o  = uop_i.priv;
        blk_iaddr_o = start_w;
        blk_cnt_o   = acc_w;
        blk_last_o  = !uop_i.compressed;
        open_o      = 1'b0;
        count_o     = '0;
        iaddr_o     = start_w;
        last_o      = !uop_i.compressed;
      end
    end
  end

endmodule

// File: rtl/multi_retire_block_fsm.sv
// Groups NRET commit lanes per cycle into retire blocks, one
// registered output slot per lane, with iretire saturation.
module multi_retire_block_fsm
  import mure_pkg::*;
#(
  parameter int unsigned NRET        = 2,
  parameter int unsigned IRETIRE_LEN = mure_pkg::IRETIRE_LEN,
  parameter bit          SAT_EN      = 1'b1
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  uop_entry_s [NRET-1:0]               uop_entry_i,
  input  logic [CAUSE_LEN-1:0]                cause_i,
  input  logic [XLEN-1:0]                     tval_i,
  output logic [NRET-1:0]                     valid_o,
  output logic [NRET-1:0][IRETIRE_LEN-1:0]    iretire_o,
  output logic [NRET-1:0]                     ilastsize_o,
  output logic [NRET-1:0][ITYPE_LEN-1:0]      itype_o,
  output logic [NRET-1:0][CAUSE_LEN-1:0]      cause_o,
  output logic [NRET-1:0][XLEN-1:0]           tval_o,
  output logic [NRET-1:0][PRIV_LEN-1:0]       priv_o,
  output logic [NRET-1:0][XLEN-1:0]           iaddr_o
);

  state_e                 state_q;
  logic [XLEN-1:0]        iaddr_q;
  logic [IRETIRE_LEN-1:0] iretire_q;
  logic                   ilastsize_q;

  logic                   pend_q, pend_d;
  logic [XLEN-1:0]        pend_iaddr_q, pend_iaddr_d;
  logic [IRETIRE_LEN-1:0] pend_cnt_q, pend_cnt_d;
  logic                   pend_last_q, pend_last_d;
  logic [PRIV_LEN-1:0]    pend_priv_q, pend_priv_d;

  logic [NRET:0]                  open_c, last_c;
  logic [NRET:0][XLEN-1:0]        iaddr_c;
  logic [NRET:0][IRETIRE_LEN-1:0] cnt_c;
  logic [NRET-1:0]                flush_c, sat_w, close_w;
  uop_entry_s [NRET-1:0]          uop_m;

  logic [NRET-1:0][XLEN-1:0]        b_iaddr, b_tval;
  logic [NRET-1:0][IRETIRE_LEN-1:0] b_cnt;
  logic [NRET-1:0]                  b_last;
  logic [NRET-1:0][ITYPE_LEN-1:0]   b_itype;
  logic [NRET-1:0][CAUSE_LEN-1:0]   b_cause;
  logic [NRET-1:0][PRIV_LEN-1:0]    b_priv;

  logic [NRET-1:0]                  out_valid_q, out_valid_d;
  logic [NRET-1:0][IRETIRE_LEN-1:0] out_iret_q, out_iret_d;
  logic [NRET-1:0]                  out_last_q, out_last_d;
  logic [NRET-1:0][ITYPE_LEN-1:0]   out_itype_q, out_itype_d;
  logic [NRET-1:0][CAUSE_LEN-1:0]   out_cause_q, out_cause_d;
  logic [NRET-1:0][XLEN-1:0]        out_tval_q, out_tval_d;
  logic [NRET-1:0][PRIV_LEN-1:0]    out_priv_q, out_priv_d;
  logic [NRET-1:0][XLEN-1:0]        out_iaddr_q, out_iaddr_d;
  logic                             placed;

  assign open_c[0]  = (state_q == COUNT);
  assign iaddr_c[0] = iaddr_q;
  assign cnt_c[0]   = iretire_q;
  assign last_c[0]  = ilastsize_q;

  // an exception/interrupt lane flushes every younger lane
  always_comb begin
    flush_c = '0;
    for (int j = 1; j < NRET; j++)
      flush_c[j] = flush_c[j-1] | is_event(uop_entry_i[j-1].itype);
  end

  for (genvar j = 0; j < NRET; j++) begin : g_lane
    assign uop_m[j] = flush_c[j] ? '0 : uop_entry_i[j];
    retire_lane_step #(
      .IRETIRE_LEN(IRETIRE_LEN),
      .SAT_EN     (SAT_EN)
    ) u_step (
      .open_i     (open_c[j]),
      .iaddr_i    (iaddr_c[j]),
      .count_i    (cnt_c[j]),
      .last_i     (last_c[j]),
      .uop_i      (uop_m[j]),
      .cause_i    (cause_i),
      .tval_i     (tval_i),
      .open_o     (open_c[j+1]),
      .iaddr_o    (iaddr_c[j+1]),
      .count_o    (cnt_c[j+1]),
      .last_o     (last_c[j+1]),
      .sat_o      (sat_w[j]),
      .close_o    (close_w[j]),
      .blk_iaddr_o(b_iaddr[j]),
      .blk_cnt_o  (b_cnt[j]),
      .blk_last_o (b_last[j]),
      .blk_itype_o(b_itype[j]),
      .blk_cause_o(b_cause[j]),
      .blk_tval_o (b_tval[j]),
      .blk_priv_o (b_priv[j])
    );
  end

  always_comb begin
    out_valid_d = '0;
    out_iret_d  = '0;
    out_last_d  = '0;
    out_itype_d = '0;
    out_cause_d = '0;
    out_tval_d  = '0;
    out_priv_d  = '0;
    out_iaddr_d = '0;
    pend_d       = pend_q;
    pend_iaddr_d = pend_iaddr_q;
    pend_cnt_d   = pend_cnt_q;
    pend_last_d  = pend_last_q;
    pend_priv_d  = pend_priv_q;
    placed       = 1'b0;
    for (int j = 0; j < NRET; j++) begin
      if (close_w[j]) begin
        out_valid_d[j] = 1'b1;
        out_iret_d[j]  = b_cnt[j];
        out_last_d[j]  = b_last[j];
        out_itype_d[j] = b_itype[j];
        out_cause_d[j] = b_cause[j];
        out_tval_d[j]  = b_tval[j];
        out_priv_d[j]  = b_priv[j];
        out_iaddr_d[j] = b_iaddr[j];
      end else if (sat_w[j]) begin
        out_valid_d[j] = 1'b1;
        out_iret_d[j]  = cnt_c[j];
        out_last_d[j]  = last_c[j];
        out_itype_d[j] = ITYPE_STD;
        out_priv_d[j]  = uop_m[j].priv;
        out_iaddr_d[j] = iaddr_c[j];
      end
    end
    // a held saturated block takes the lowest free slot
    for (int j = 0; j < NRET; j++) begin
      if (pend_q && !placed && !out_valid_d[j]) begin
        placed         = 1'b1;
        out_valid_d[j] = 1'b1;
        out_iret_d[j]  = pend_cnt_q;
        out_last_d[j]  = pend_last_q;
        out_itype_d[j] = ITYPE_STD;
        out_priv_d[j]  = pend_priv_q;
        out_iaddr_d[j] = pend_iaddr_q;
      end
    end
    if (placed) pend_d = 1'b0;
    for (int j = 0; j < NRET; j++) begin
      if (sat_w[j] && close_w[j]) begin
        pend_d       = 1'b1;
        pend_iaddr_d = iaddr_c[j];
        pend_cnt_d   = cnt_c[j];
        pend_last_d  = last_c[j];
        pend_priv_d  = uop_m[j].priv;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      iaddr_q      <= '0;
      iretire_q    <= '0;
      ilastsize_q  <= 1'b0;
      pend_q       <= 1'b0;
      pend_iaddr_q <= '0;
      pend_cnt_q   <= '0;
      pend_last_q  <= 1'b0;
      pend_priv_q  <= '0;
      out_valid_q  <= '0;
      out_iret_q   <= '0;
      out_last_q   <= '0;
      out_itype_q  <= '0;
      out_cause_q  <= '0;
      out_tval_q   <= '0;
      out_priv_q   <= '0;
      out_iaddr_q  <= '0;
    end else begin
      state_q      <= open_c[NRET] ? COUNT : IDLE;
      iaddr_q      <= iaddr_c[NRET];
      iretire_q    <= cnt_c[NRET];
      ilastsize_q  <= last_c[NRET];
      pend_q       <= pend_d;
      pend_iaddr_q <= pend_iaddr_d;
      pend_cnt_q   <= pend_cnt_d;
      pend_last_q  <= pend_last_d;
      pend_priv_q  <= pend_priv_d;
      out_valid_q  <= out_valid_d;
      out_iret_q   <= out_iret_d;
      out_last_q   <= out_last_d;
      out_itype_q  <= out_itype_d;
      out_cause_q  <= out_cause_d;
      out_tval_q   <= out_tval_d;
      out_priv_q   <= out_priv_d;
      out_iaddr_q  <= out_iaddr_d;
    end
  end

  assign valid_o     = out_valid_q;
  assign iretire_o   = out_iret_q;
  assign ilastsize_o = out_last_q;
  assign itype_o     = out_itype_q;
  assign cause_o     = out_cause_q;
  assign tval_o      = out_tval_q;
  assign priv_o      = out_priv_q;
  assign iaddr_o     = out_iaddr_q;

endmodule

// File: tb/tb_multi_retire_block_fsm.sv
// Directed bench: block grouping, flush, empty blocks, reset and
// saturation/wrap on narrow-iretire instances.
module tb_multi_retire_block_fsm;
  import mure_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  uop_entry_s [1:0] um, us;
  logic [4:0]  cm, cs;
  logic [31:0] tm, ts;

  logic [1:0]       v_m, ls_m;
  logic [1:0][7:0]  ir_m;
  logic [1:0][3:0]  it_m;
  logic [1:0][4:0]  ca_m;
  logic [1:0][31:0] tv_m, ia_m;
  logic [1:0][1:0]  pr_m;

  logic [1:0]       v_s, ls_s;
  logic [1:0][3:0]  ir_s, it_s;
  logic [1:0][4:0]  ca_s;
  logic [1:0][31:0] tv_s, ia_s;
  logic [1:0][1:0]  pr_s;

  logic [1:0]       v_w, ls_w;
  logic [1:0][3:0]  ir_w, it_w;
  logic [1:0][4:0]  ca_w;
  logic [1:0][31:0] tv_w, ia_w;
  logic [1:0][1:0]  pr_w;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multi_retire_block_fsm #(.NRET(2)) u_main (
    .clk_i(clk), .rst_i(rst), .uop_entry_i(um),
    .cause_i(cm), .tval_i(tm), .valid_o(v_m),
    .iretire_o(ir_m), .ilastsize_o(ls_m), .itype_o(it_m),
    .cause_o(ca_m), .tval_o(tv_m), .priv_o(pr_m),
    .iaddr_o(ia_m)
  );

  multi_retire_block_fsm #(
    .NRET(2), .IRETIRE_LEN(4), .SAT_EN(1'b1)
  ) u_sat (
    .clk_i(clk), .rst_i(rst), .uop_entry_i(us),
    .cause_i(cs), .tval_i(ts), .valid_o(v_s),
    .iretire_o(ir_s), .ilastsize_o(ls_s), .itype_o(it_s),
    .cause_o(ca_s), .tval_o(tv_s), .priv_o(pr_s),
    .iaddr_o(ia_s)
  );

  multi_retire_block_fsm #(
    .NRET(2), .IRETIRE_LEN(4), .SAT_EN(1'b0)
  ) u_wrap (
    .clk_i(clk), .rst_i(rst), .uop_entry_i(us),
    .cause_i(cs), .tval_i(ts), .valid_o(v_w),
    .iretire_o(ir_w), .ilastsize_o(ls_w), .itype_o(it_w),
    .cause_o(ca_w), .tval_o(tv_w), .priv_o(pr_w),
    .iaddr_o(ia_w)
  );

  function automatic uop_entry_s mk(input logic v,
    input logic [31:0] a, input logic [3:0] t,
    input logic c, input logic [1:0] p);
    mk = '{valid: v, pc: a, itype: t, compressed: c, priv: p};
  endfunction

  task automatic clr();
    um = '0; us = '0;
    cm = '0; cs = '0;
    tm = '0; ts = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr();
    rst = 1'b1;
    tick();
    tick();
    if ({v_m, ir_m, ls_m, it_m, ca_m, tv_m, pr_m, ia_m} !== '0) begin
      errors++; $display("FAIL reset_main got %h exp 0", {v_m, ir_m, ia_m});
    end
    checks++;
    if ({v_s, ir_s, ia_s, v_w, ir_w, ia_w} !== '0) begin
      errors++; $display("FAIL reset_narrow got %h exp 0", {v_s, ir_s, v_w, ir_w});
    end
    checks++;
    rst = 1'b0;
  endtask

  task automatic test_two_cycle_block();
    um[0] = mk(1, 32'h100, 4'd0, 1, 2'd0);
    um[1] = mk(1, 32'h102, 4'd0, 0, 2'd0);
    tick(); clr();
    if (v_m !== 2'b00) begin
      errors++; $display("FAIL t2_open_valid got %b exp 00", v_m);
    end
    checks++;
    um[0] = mk(1, 32'h106, 4'd4, 0, 2'd1);
    tick(); clr();
    if (v_m !== 2'b01) begin
      errors++; $display("FAIL t2_valid got %b exp 01", v_m);
    end
    checks++;
    if ({ia_m[0], ir_m[0], ls_m[0], it_m[0], pr_m[0]} !== {32'h100, 8'd5, 1'b1, 4'd4, 2'd1}) begin
      errors++; $display("FAIL t2_slot0 got ia %h ir %0d ls %b it %0d pr %0d exp 100 5 1 4 1",
        ia_m[0], ir_m[0], ls_m[0], it_m[0], pr_m[0]);
    end
    checks++;
    if ({ia_m[1], ir_m[1], it_m[1]} !== '0) begin
      errors++; $display("FAIL t2_slot1_zero got ia %h ir %0d exp 0", ia_m[1], ir_m[1]);
    end
    checks++;
    tick();
    if (v_m !== 2'b00) begin
      errors++; $display("FAIL t2_pulse got %b exp 00", v_m);
    end
    checks++;
  endtask

  task automatic test_empty_event();
    um[0] = mk(0, 32'h999, 4'd2, 0, 2'd0);
    cm = 5'd7; tm = 32'h1234;
    tick(); clr();
    if (v_m !== 2'b01 || it_m[0] !== 4'd2) begin
      errors++; $display("FAIL t6_valid got %b it %0d exp 01 2", v_m, it_m[0]);
    end
    checks++;
    if ({ir_m[0], ia_m[0], ca_m[0], tv_m[0]} !== {8'd0, 32'h100, 5'd7, 32'd0}) begin
      errors++; $display("FAIL t6_fields got ir %0d ia %h ca %0d tv %h exp 0 100 7 0",
        ir_m[0], ia_m[0], ca_m[0], tv_m[0]);
    end
    checks++;
  endtask

  task automatic test_dual_close();
    um[0] = mk(1, 32'h200, 4'd4, 1, 2'd3);
    um[1] = mk(1, 32'h202, 4'd5, 0, 2'd1);
    cm = 5'd3; tm = 32'hffff;
    tick(); clr();
    if (v_m !== 2'b11) begin
      errors++; $display("FAIL t3_valid got %b exp 11", v_m);
    end
    checks++;
    if ({ia_m[0], ir_m[0], ls_m[0], it_m[0], pr_m[0]} !== {32'h200, 8'd1, 1'b0, 4'd4, 2'd3}) begin
      errors++; $display("FAIL t3_slot0 got ia %h ir %0d ls %b it %0d exp 200 1 0 4",
        ia_m[0], ir_m[0], ls_m[0], it_m[0]);
    end
    checks++;
    if ({ia_m[1], ir_m[1], ls_m[1], it_m[1], pr_m[1]} !== {32'h202, 8'd2, 1'b1, 4'd5, 2'd1}) begin
      errors++; $display("FAIL t3_slot1 got ia %h ir %0d ls %b it %0d exp 202 2 1 5",
        ia_m[1], ir_m[1], ls_m[1], it_m[1]);
    end
    checks++;
    if ({ca_m, tv_m} !== '0) begin
      errors++; $display("FAIL t3_cause_tval got %h %h exp 0", ca_m, tv_m);
    end
    checks++;
  endtask

  task automatic test_flush();
    um[0] = mk(1, 32'h400, 4'd0, 1, 2'd0);
    um[1] = mk(1, 32'h402, 4'd0, 1, 2'd0);
    tick();
    um[0] = mk(1, 32'h404, 4'd0, 1, 2'd0);
    um[1] = mk(1, 32'h406, 4'd0, 1, 2'd0);
    tick(); clr();
    um[0] = mk(0, 32'h0, 4'd1, 0, 2'd0);
    um[1] = mk(1, 32'h408, 4'd0, 0, 2'd0);
    cm = 5'd2; tm = 32'hdead;
    tick(); clr();
    if (v_m !== 2'b01) begin
      errors++; $display("FAIL t4_valid got %b exp 01", v_m);
    end
    checks++;
    if ({ia_m[0], ir_m[0], ls_m[0], it_m[0], ca_m[0], tv_m[0]} !==
        {32'h400, 8'd4, 1'b0, 4'd1, 5'd2, 32'hdead}) begin
      errors++; $display("FAIL t4_slot0 got ia %h ir %0d ls %b it %0d ca %0d tv %h exp 400 4 0 1 2 dead",
        ia_m[0], ir_m[0], ls_m[0], it_m[0], ca_m[0], tv_m[0]);
    end
    checks++;
    um[0] = mk(1, 32'h500, 4'd4, 1, 2'd0);
    tick(); clr();
    if ({v_m, ia_m[0], ir_m[0]} !== {2'b01, 32'h500, 8'd1}) begin
      errors++; $display("FAIL t4_after_idle got v %b ia %h ir %0d exp 01 500 1",
        v_m, ia_m[0], ir_m[0]);
    end
    checks++;
  endtask

  task automatic test_reset_mid_block();
    um[0] = mk(1, 32'h600, 4'd0, 0, 2'd0);
    um[1] = mk(1, 32'h604, 4'd0, 0, 2'd0);
    tick(); clr();
    um[0] = mk(1, 32'h608, 4'd0, 0, 2'd0);
    tick(); clr();
    #2 rst = 1'b1;
    #2;
    if ({v_m, ir_m, ls_m, it_m, ca_m, tv_m, pr_m, ia_m} !== '0) begin
      errors++; $display("FAIL t1_reset_out got %h exp 0", {v_m, ir_m, ia_m});
    end
    checks++;
    rst = 1'b0;
    um[0] = mk(1, 32'h700, 4'd4, 0, 2'd0);
    tick(); clr();
    if ({v_m, ia_m[0], ir_m[0], ls_m[0]} !== {2'b01, 32'h700, 8'd2, 1'b1}) begin
      errors++; $display("FAIL t1_new_block got v %b ia %h ir %0d exp 01 700 2",
        v_m, ia_m[0], ir_m[0]);
    end
    checks++;
  endtask

  task automatic build14(input logic [31:0] b);
    for (int k = 0; k < 3; k++) begin
      us[0] = mk(1, b + 32'(8 * k), 4'd0, 0, 2'd0);
      us[1] = mk(1, b + 32'(8 * k + 4), 4'd0, 0, 2'd0);
      tick(); clr();
    end
    us[0] = mk(1, b + 32'h18, 4'd0, 0, 2'd0);
    tick(); clr();
    if ({v_s, v_w} !== 4'b0000) begin
      errors++; $display("FAIL build_quiet got %b %b exp 00 00", v_s, v_w);
    end
    checks++;
  endtask

  task automatic test_saturate();
    build14(32'h280);
    us[0] = mk(1, 32'h300, 4'd0, 0, 2'd0);
    us[1] = mk(1, 32'h304, 4'd4, 1, 2'd0);
    tick(); clr();
    if (v_s !== 2'b11) begin
      errors++; $display("FAIL t5_valid got %b exp 11", v_s);
    end
    checks++;
    if ({ia_s[0], ir_s[0], ls_s[0], it_s[0]} !== {32'h280, 4'd14, 1'b1, 4'd0}) begin
      errors++; $display("FAIL t5_sat_slot got ia %h ir %0d ls %b it %0d exp 280 14 1 0",
        ia_s[0], ir_s[0], ls_s[0], it_s[0]);
    end
    checks++;
    if ({ia_s[1], ir_s[1], ls_s[1], it_s[1]} !== {32'h300, 4'd3, 1'b0, 4'd4}) begin
      errors++; $display("FAIL t5_new_block got ia %h ir %0d ls %b it %0d exp 300 3 0 4",
        ia_s[1], ir_s[1], ls_s[1], it_s[1]);
    end
    checks++;
    if ({v_w, ia_w[1], ir_w[1], it_w[1]} !== {2'b10, 32'h280, 4'd1, 4'd4}) begin
      errors++; $display("FAIL wrap_block got v %b ia %h ir %0d it %0d exp 10 280 1 4",
        v_w, ia_w[1], ir_w[1], it_w[1]);
    end
    checks++;
  endtask

  task automatic test_sat_with_close();
    build14(32'h800);
    us[0] = mk(1, 32'h900, 4'd4, 0, 2'd0);
    tick(); clr();
    if ({v_s, ia_s[0], ir_s[0], ls_s[0], it_s[0]} !== {2'b01, 32'h900, 4'd2, 1'b1, 4'd4}) begin
      errors++; $display("FAIL satc_close got v %b ia %h ir %0d it %0d exp 01 900 2 4",
        v_s, ia_s[0], ir_s[0], it_s[0]);
    end
    checks++;
    if ({v_w, ia_w[0], ir_w[0]} !== {2'b01, 32'h800, 4'd0}) begin
      errors++; $display("FAIL wrap_zero got v %b ia %h ir %0d exp 01 800 0",
        v_w, ia_w[0], ir_w[0]);
    end
    checks++;
    tick();
    if ({v_s, ia_s[0], ir_s[0], ls_s[0], it_s[0]} !== {2'b01, 32'h800, 4'd14, 1'b1, 4'd0}) begin
      errors++; $display("FAIL satc_pending got v %b ia %h ir %0d it %0d exp 01 800 14 0",
        v_s, ia_s[0], ir_s[0], it_s[0]);
    end
    checks++;
    tick();
    if (v_s !== 2'b00) begin
      errors++; $display("FAIL satc_drained got %b exp 00", v_s);
    end
    checks++;
  endtask

  initial begin
    clr();
    test_reset();
    test_two_cycle_block();
    test_empty_event();
    test_dual_close();
    test_flush();
    test_reset_mid_block();
    test_saturate();
    test_sat_with_close();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
